// File: rtl/fregfile_wb.sv
// ---------------------------------------------------------------------------
// fregfile_wb -- floating-point register file with two write sources.
//
// Purpose:
//   NRD combinational read ports over an NREG x FLEN array. The primary port
//   (in-order FPU writeback) always wins the array write slot. The secondary
//   port (long-latency units such as fdivsqrt) goes through a small in-order
//   write buffer, so it never collides with a primary write. The block also
//   keeps a per-register busy scoreboard for long-latency destinations, and
//   the dirty flag that feeds mstatus.FS.
//
// Optional feature (macro FREGFILE_BYPASS_EN):
//   When defined, each read port forwards the data being committed this cycle
//   if its address matches, so a write is visible to reads with no delay.
//   When undefined, reads return the array contents only.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   ra         in   NRD*AW read addresses, port i = ra[i*AW +: AW]
//   rd         out  NRD*FLEN read data, port i = rd[i*FLEN +: FLEN]
//   we_p       in   primary write enable
//   wa_p/wd_p  in   primary write address / data
//   we_s       in   secondary write valid (held by producer until s_ready)
//   wa_s/wd_s  in   secondary write address / data
//   s_ready    out  secondary write accepted when we_s && s_ready
//   set_busy   in   mark busy_addr busy (long-latency op issued)
//   busy_addr  in   register to mark busy
//   busy       out  NREG registered busy vector
//   clr_dirty  in   clear the dirty flag
//   dirty      out  set once any register has been written
// ---------------------------------------------------------------------------
module fregfile_wb #(
    parameter int FLEN    = 64,
    parameter int NREG    = 32,
    parameter int NRD     = 3,
    parameter int WBDEPTH = 2,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*FLEN-1:0]  rd,
    input  logic                 we_p,
    input  logic [AW-1:0]        wa_p,
    input  logic [FLEN-1:0]      wd_p,
    input  logic                 we_s,
    input  logic [AW-1:0]        wa_s,
    input  logic [FLEN-1:0]      wd_s,
    output logic                 s_ready,
    input  logic                 set_busy,
    input  logic [AW-1:0]        busy_addr,
    output logic [NREG-1:0]      busy,
    input  logic                 clr_dirty,
    output logic                 dirty
);

    // Pointer width stays at least 1 bit so WBDEPTH == 1 still elaborates.
    localparam int PW = (WBDEPTH > 1) ? $clog2(WBDEPTH) : 1;
    localparam int CW = $clog2(WBDEPTH + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [FLEN-1:0] rf       [NREG];
    logic [AW-1:0]   buf_addr [WBDEPTH];
    logic [FLEN-1:0] buf_data [WBDEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    // ------------------------------------------------------------------
    // Secondary path control
    // ------------------------------------------------------------------
    logic            buf_empty;
    logic            accept;
    logic            cand_valid;
    logic [AW-1:0]   cand_addr;
    logic [FLEN-1:0] cand_data;
    logic            commit_p;
    logic            commit_s;
    logic            push;
    logic            pop;
    logic [NREG-1:0] busy_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(WBDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Full blocks acceptance even if the head drains this cycle; keeps the
    // ready path a pure function of registered state.
    assign s_ready    = (count < CW'(WBDEPTH));
    assign buf_empty  = (count == '0);
    assign accept     = we_s && s_ready;

    // The buffer head always goes before a new arrival so order is preserved;
    // a new write skips the buffer only when nothing is queued ahead of it.
    assign cand_valid = !buf_empty || accept;
    assign cand_addr  = buf_empty ? wa_s : buf_addr[head];
    assign cand_data  = buf_empty ? wd_s : buf_data[head];

    // Reset suppresses every commit so nothing lands during the reset cycle.
    assign commit_p   = !reset && we_p;
    assign commit_s   = !reset && !we_p && cand_valid;
    assign pop        = commit_s && !buf_empty;
    assign push       = !reset && accept && (we_p || !buf_empty);

    // Set is applied after clear so a same-cycle set on the committing
    // register leaves it busy.
    always_comb begin
        busy_nxt = busy;
        if (commit_s)
            busy_nxt[cand_addr] = 1'b0;
        if (set_busy)
            busy_nxt[busy_addr] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Array, pointers, scoreboard, dirty
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            dirty <= 1'b0;
        end else begin
            // commit_p and commit_s are mutually exclusive by construction.
            if (commit_p)
                rf[wa_p] <= wd_p;
            if (commit_s)
                rf[cand_addr] <= cand_data;

            if (push)
                tail <= ptr_inc(tail);
            if (pop)
                head <= ptr_inc(head);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            busy <= busy_nxt;

            if (commit_p || commit_s)
                dirty <= 1'b1;
            else if (clr_dirty)
                dirty <= 1'b0;
        end
    end

    // Buffer payload needs no reset: count gates every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[tail] <= wa_s;
            buf_data[tail] <= wd_s;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        assign a = ra[i*AW +: AW];
`ifdef FREGFILE_BYPASS_EN
        assign rd[i*FLEN +: FLEN] =
            (commit_p && (wa_p == a))      ? wd_p      :
            (commit_s && (cand_addr == a)) ? cand_data :
                                             rf[a];
`else
        assign rd[i*FLEN +: FLEN] = rf[a];
`endif
    end

endmodule

// File: tb/tb_fregfile_wb.sv
module tb_fregfile_wb;
    localparam int FLEN    = 64;
    localparam int NREG    = 32;
    localparam int NRD     = 3;
    localparam int WBDEPTH = 2;
    localparam int AW      = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*FLEN-1:0] rd;
    logic                we_p;
    logic [AW-1:0]       wa_p;
    logic [FLEN-1:0]     wd_p;
    logic                we_s;
    logic [AW-1:0]       wa_s;
    logic [FLEN-1:0]     wd_s;
    logic                s_ready;
    logic                set_busy;
    logic [AW-1:0]       busy_addr;
    logic [NREG-1:0]     busy;
    logic                clr_dirty;
    logic                dirty;

    fregfile_wb #(.FLEN(FLEN), .NREG(NREG), .NRD(NRD), .WBDEPTH(WBDEPTH)) dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd),
        .we_p(we_p), .wa_p(wa_p), .wd_p(wd_p),
        .we_s(we_s), .wa_s(wa_s), .wd_s(wd_s), .s_ready(s_ready),
        .set_busy(set_busy), .busy_addr(busy_addr), .busy(busy),
        .clr_dirty(clr_dirty), .dirty(dirty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NRD*FLEN-1:0] rd;
        logic [NREG-1:0]     busy;
        logic                dirty;
        logic                s_ready;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: architectural registers plus a FIFO of writes that
    // have been accepted but not yet written.
    logic [FLEN-1:0]    m_rf [NREG];
    logic [AW+FLEN-1:0] m_pend[$];
    logic [NREG-1:0]    m_busy;
    logic               m_dirty;
    bit                 m_valid = 0;
    bit                 last_acc;
    bit                 hold_s = 0;

    function automatic logic [FLEN-1:0] m_read(input logic [AW-1:0] a);
        logic [FLEN-1:0] v;
        v = m_rf[a];
`ifdef FREGFILE_BYPASS_EN
        if (!reset && we_p) begin
            if (wa_p == a) v = wd_p;
        end else if (!reset) begin
            logic [AW+FLEN-1:0] h;
            logic               hv;
            hv = 1'b0;
            h  = '0;
            if (m_pend.size() > 0) begin h = m_pend[0]; hv = 1'b1; end
            else if (we_s && m_pend.size() < WBDEPTH) begin h = {wa_s, wd_s}; hv = 1'b1; end
            if (hv && h[AW+FLEN-1:FLEN] == a) v = h[FLEN-1:0];
        end
`endif
        return v;
    endfunction

    task automatic model_update();
        logic [AW+FLEN-1:0] e;
        bit acc;
        acc = we_s && (m_pend.size() < WBDEPTH);
        last_acc = acc && !reset;
        hold_s = we_s && !acc && !reset;
        if (reset) begin
            for (int i = 0; i < NREG; i++) m_rf[i] = '0;
            m_pend.delete();
            m_busy  = '0;
            m_dirty = 1'b0;
            m_valid = 1;
            return;
        end
        if (acc) m_pend.push_back({wa_s, wd_s});
        if (we_p) begin
            m_rf[wa_p] = wd_p;
            m_dirty = 1'b1;
        end else if (m_pend.size() > 0) begin
            e = m_pend.pop_front();
            m_rf[e[AW+FLEN-1:FLEN]] = e[FLEN-1:0];
            m_busy[e[AW+FLEN-1:FLEN]] = 1'b0;
            m_dirty = 1'b1;
        end else if (clr_dirty) begin
            m_dirty = 1'b0;
        end
        if (set_busy) m_busy[busy_addr] = 1'b1;
    endtask

    // One clock cycle: record what the outputs must show with the inputs now
    // applied, then let the edge happen and advance the model.
    task automatic tick();
        exp_t e;
        if (m_valid) begin
            for (int i = 0; i < NRD; i++) e.rd[i*FLEN +: FLEN] = m_read(ra[i*AW +: AW]);
            e.busy    = m_busy;
            e.dirty   = m_dirty;
            e.s_ready = (m_pend.size() < WBDEPTH);
            expq.push_back(e);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        reset = 0; we_p = 0; wa_p = '0; wd_p = '0;
        we_s = 0; wa_s = '0; wd_s = '0;
        set_busy = 0; busy_addr = '0; clr_dirty = 0;
    endtask

    task automatic set_ra(input int a0, input int a1, input int a2);
        ra = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare against the oldest expectation each sample point.
    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                for (int i = 0; i < NRD; i++)
                    chk($sformatf("rd%0d", i), rd[i*FLEN +: FLEN], e.rd[i*FLEN +: FLEN]);
                chk("busy", 64'(busy), 64'(e.busy));
                chk("dirty", 64'(dirty), 64'(e.dirty));
                chk("s_ready", 64'(s_ready), 64'(e.s_ready));
            end
        end
    end

    initial begin
        int idx;
        logic [FLEN-1:0] d3 [3];
        idle();
        set_ra(0, 5, 31);
        @(posedge clk); #1;

        // 1: reset, then read 0/5/31
        reset = 1; tick();
        idle(); set_ra(0, 5, 31); tick();

        // 2: primary write then read back
        we_p = 1; wa_p = 3; wd_p = 64'h4000_0000_0000_0000; set_ra(3, 0, 3); tick();
        idle(); tick();

        // 3: busy, then secondary write blocked by primary, then drain
        set_busy = 1; busy_addr = 7; tick();
        idle(); tick();
        we_p = 1; wa_p = 1; wd_p = 64'h11; we_s = 1; wa_s = 7; wd_s = 64'hAA; set_ra(7, 1, 3); tick();
        idle(); tick();
        tick();

        // 4: three secondary writes while primary holds the slot
        d3[0] = 64'hA1; d3[1] = 64'hA2; d3[2] = 64'hA3;
        idx = 0; set_ra(20, 21, 22);
        for (int c = 0; c < 12; c++) begin
            idle();
            we_p = (c < 4);
            wa_p = 10; wd_p = 64'(c);
            if (idx < 3) begin we_s = 1; wa_s = AW'(20 + idx); wd_s = d3[idx]; end
            tick();
            if (last_acc) idx++;
        end

        // 5: set_busy and commit to the same register; clr_dirty with write
        idle(); we_s = 1; wa_s = 9; wd_s = 64'h99; set_busy = 1; busy_addr = 9; set_ra(9, 9, 9); tick();
        idle(); tick();
        clr_dirty = 1; we_p = 1; wa_p = 2; wd_p = 64'h22; tick();
        idle(); clr_dirty = 1; tick();
        idle(); tick();

        // 6: reset with two entries buffered and busy[4] set
        we_p = 1; wa_p = 0; wd_p = 64'h5; set_busy = 1; busy_addr = 4;
        we_s = 1; wa_s = 4; wd_s = 64'hDEAD; set_ra(4, 6, 0); tick();
        set_busy = 0; wa_s = 6; wd_s = 64'hBEEF; tick();
        idle(); reset = 1; set_ra(4, 6, 0); tick();
        idle(); set_ra(4, 6, 0); tick();
        tick();

        // Random traffic with a legal, holding producer.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            we_p      = ($urandom_range(0, 2) == 0);
            wa_p      = AW'($urandom_range(0, 7));
            wd_p      = {$urandom, $urandom};
            if (!hold_s) begin
                we_s = ($urandom_range(0, 1) == 0);
                wa_s = AW'($urandom_range(0, 7));
                wd_s = {$urandom, $urandom};
            end
            set_busy  = ($urandom_range(0, 3) == 0);
            busy_addr = AW'($urandom_range(0, 7));
            clr_dirty = ($urandom_range(0, 5) == 0);
            set_ra($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31));
            tick();
        end
        idle();
        tick();
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fregfile_wb.md
Name: fregfile_wb

Overview:
- Parametrised FP register file: NRD combinational read ports, two write sources.
- Primary write port: the in-order FPU writeback stage.
- Secondary write port: long-latency units (fdivsqrt). It has a small in-order write buffer so it never collides with primary writes.
- Also holds a per-register busy scoreboard for long-latency destinations and the dirty flag that feeds mstatus.FS.

Parameters:
- FLEN, 64, register width in bits
- NREG, 32, number of registers (power of 2; address width AW = log2(NREG))
- NRD, 3, number of read ports
- WBDEPTH, 2, secondary write-buffer entries (>=1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ra  in  NRD*AW  read addresses; port i = ra[i*AW +: AW]
- rd  out  NRD*FLEN  read data; port i = rd[i*FLEN +: FLEN]
- we_p  in  1  primary write enable
- wa_p  in  AW  primary write address
- wd_p  in  FLEN  primary write data
- we_s  in  1  secondary write valid
- wa_s  in  AW  secondary write address
- wd_s  in  FLEN  secondary write data
- s_ready  out  1  secondary write accepted this cycle when we_s && s_ready
- set_busy  in  1  mark register busy (long-latency op issued)
- busy_addr  in  AW  register to mark busy
- busy  out  NREG  per-register busy vector (registered)
- clr_dirty  in  1  clear dirty flag
- dirty  out  1  set when any register has been written

Behaviour:
Reset:
- Reset is synchronous and active-high.
- On reset: every register = 0, buffer emptied (in-flight secondary writes discarded), busy = 0, dirty = 0.
- s_ready = 1 in the first cycle after reset.
- Reset beats every other input in the same cycle.

Reads:
- rd[i] = rf[ra[i]], purely combinational.
- Reads return the pre-edge array contents unless FREGFILE_BYPASS_EN is defined.

Primary writes:
- When we_p = 1, rf[wa_p] <= wd_p at the edge. Always accepted, no stall.

Secondary writes (one array commit per cycle, from C below):
- Candidate C: the buffer head if the buffer is non-empty; otherwise the new accepted secondary write.
- If we_p = 0 and C exists: commit C to the array. A new accepted write is enqueued only when the buffer was non-empty, so strict arrival order is kept.
- If we_p = 1: nothing drains; an accepted secondary write is enqueued.
- s_ready = (count < WBDEPTH), computed combinationally from the registered count.
- When full, s_ready = 0 even if a drain happens this cycle.
- count updates: +1 on enqueue, -1 on drain, unchanged if both happen, never exceeds WBDEPTH.

Busy scoreboard:
- busy[busy_addr] <= 1 on set_busy.
- busy[a] <= 0 when a secondary write to address a commits to the array. Enqueueing into the buffer does not clear busy.
- Set and clear of the same register in the same cycle: set wins.
- Primary writes never touch busy.

Dirty flag:
- dirty <= 1 on any array commit (primary or secondary).
- Otherwise dirty <= 0 on clr_dirty.
- Commit and clr_dirty in the same cycle: dirty = 1.

Latency:
- Primary write visible to reads on the cycle after the edge.
- Secondary write visible 1 + (cycles spent in buffer) cycles after acceptance.

Undefined behaviour:
- Two buffered entries to the same address are legal; the later one wins.
- we_s while !s_ready: the producer must hold the write; it is not sampled.

Optional Feature:
Macro FREGFILE_BYPASS_EN.
- Defined: each read port forwards data being committed this cycle when the addresses match. Primary write data or the draining secondary data (never both at once) is returned instead of the array value. This gives zero-cycle write-to-read visibility.
- Undefined: reads return array contents only. Pipeline hazard logic handles the one-cycle gap.

Test Plan:
1. Reset then read all ports at addresses 0, 5, 31 -> rd = 0; busy = 0; dirty = 0; s_ready = 1.
2. we_p with wa_p=3, wd_p=64'h4000_0000_0000_0000; next cycle ra0=3 -> rd0 = 64'h4000_0000_0000_0000; dirty = 1. With FREGFILE_BYPASS_EN, rd0 shows the value in the write cycle itself.
3. set_busy with busy_addr=7. Two cycles later we_s with wa_s=7, wd_s=0xAA and we_p=1 in the same cycle -> entry buffered, busy[7] still 1. Next cycle we_p=0 -> rf[7]=0xAA and busy[7] clears after that edge.
4. Hold we_p=1 and present 3 secondary writes, WBDEPTH=2 -> first two accepted, s_ready = 0 on the third. Drop we_p -> drains in order, one per cycle. Third is accepted when count drops to 1. All three land in arrival order.
5. In the same cycle: set_busy with busy_addr=9, and a secondary commit to register 9 -> busy[9] = 1. Separately, clr_dirty together with a primary write -> dirty = 1.
6. Assert reset with 2 entries buffered and busy[4]=1 -> next cycle count = 0, s_ready = 1, busy = 0, and the buffered data never reaches the array.
